// File: rtl/dbus_byte_tx_if.sv
// Byte-side request/status and open-drain line signals of the DBUS byte transmitter.
interface dbus_byte_tx_if;
  logic [7:0] i_data;
  logic       i_enable;
  logic       i_tip;
  logic       i_ring;
  logic       o_tip_drive;
  logic       o_ring_drive;
  logic       o_busy;
  logic       o_done;
  logic       o_error;

  modport master (
    output i_data, i_enable, i_tip, i_ring,
    input  o_tip_drive, o_ring_drive, o_busy, o_done, o_error
  );

  modport slave (
    input  i_data, i_enable, i_tip, i_ring,
    output o_tip_drive, o_ring_drive, o_busy, o_done, o_error
  );
endinterface

// File: rtl/dbus_byte_tx.sv
// DBUS transmitter: sends one byte LSB-first with the four-phase tip/ring handshake,
// aborting any phase that waits longer than c_TIMEOUT cycles.
module dbus_byte_tx #(
  parameter int unsigned c_TIMEOUT      = 65535,
  parameter int unsigned c_TIMEOUTWIDTH = 16
) (
  input logic            i_clock,
  input logic            i_reset,
  dbus_byte_tx_if.slave  bus
);

  localparam int unsigned TW = c_TIMEOUTWIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_WAITIDLE, S_ASSERT, S_RELEASE, S_NEXT, S_DONE, S_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  cnt_q,   cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0]  tip_sync_q, ring_sync_q;

  logic tip_drive_q,  tip_drive_d;
  logic ring_drive_q, ring_drive_d;
  logic busy_q,  busy_d;
  logic done_q,  done_d;
  logic error_q, error_d;

  logic s_tip, s_ring, ack_low, both_high, tmo_hit, waiting;

  assign s_tip     = tip_sync_q[1];
  assign s_ring    = ring_sync_q[1];
  // A one-bit is driven on ring and acknowledged on tip; a zero-bit the reverse.
  assign ack_low   = shift_q[0] ? ~s_tip : ~s_ring;
  assign both_high = s_tip & s_ring;
  assign tmo_hit   = (tmo_q == TW'(c_TIMEOUT));
  assign waiting   = (state_q == S_WAITIDLE) || (state_q == S_ASSERT) ||
                     (state_q == S_RELEASE);

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next state and datapath
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_enable) begin
          shift_d = bus.i_data;
          cnt_d   = 3'd0;
          state_d = S_WAITIDLE;
        end
      end
      S_WAITIDLE: begin
        if (tmo_hit)        state_d = S_ERROR;
        else if (both_high) state_d = S_ASSERT;
      end
      S_ASSERT: begin
        if (tmo_hit)      state_d = S_ERROR;
        else if (ack_low) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (tmo_hit)        state_d = S_ERROR;
        else if (both_high) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (cnt_q == 3'd7) begin
          state_d = S_DONE;
        end else begin
          shift_d = {1'b0, shift_q[7:1]};
          cnt_d   = cnt_q + 3'd1;
          state_d = S_ASSERT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) tmo_d = TW'(0);
    else if (waiting)       tmo_d = tmo_q + TW'(1);
    else                    tmo_d = TW'(0);
  end

  // Outputs decoded from the upcoming state so they register in step with it
  always_comb begin
    tip_drive_d  = 1'b0;
    ring_drive_d = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    error_d      = 1'b0;
    if (state_d == S_ASSERT) begin
      tip_drive_d  = ~shift_d[0];
      ring_drive_d =  shift_d[0];
    end
    busy_d  = (state_d == S_WAITIDLE) || (state_d == S_ASSERT) ||
              (state_d == S_RELEASE)  || (state_d == S_NEXT);
    done_d  = (state_d == S_DONE);
    error_d = (state_d == S_ERROR);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      shift_q      <= 8'd0;
      cnt_q        <= 3'd0;
      tmo_q        <= TW'(0);
      tip_sync_q   <= 2'b11;
      ring_sync_q  <= 2'b11;
      tip_drive_q  <= 1'b0;
      ring_drive_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      tip_sync_q   <= {tip_sync_q[0], bus.i_tip};
      ring_sync_q  <= {ring_sync_q[0], bus.i_ring};
      tip_drive_q  <= tip_drive_d;
      ring_drive_q <= ring_drive_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign bus.o_tip_drive  = tip_drive_q;
  assign bus.o_ring_drive = ring_drive_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_done       = done_q;
  assign bus.o_error      = error_q;

endmodule

// File: tb/tb_dbus_byte_tx.sv
// Directed bench for dbus_byte_tx with a behavioural DBUS receiver on the open-drain lines.
module tb_dbus_byte_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dbus_byte_tx_if bus ();

  dbus_byte_tx #(.c_TIMEOUT(16), .c_TIMEOUTWIDTH(5)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  // Wired-AND lines: low if the DUT, the peer, or the bench holds them down
  logic peer_en = 1'b0, peer_tip = 1'b0, peer_ring = 1'b0, ring_hold = 1'b0;
  int   pcnt = 0;
  assign bus.i_tip  = ~(bus.o_tip_drive  | peer_tip);
  assign bus.i_ring = ~(bus.o_ring_drive | peer_ring | ring_hold);

  // Receiver: acknowledge a held drive after 5 cycles, release once the drive drops
  always @(posedge clk) begin
    if (!peer_en) begin
      peer_tip <= 1'b0; peer_ring <= 1'b0; pcnt <= 0;
    end else begin
      if (bus.o_tip_drive && !peer_ring) begin
        if (pcnt == 4) begin peer_ring <= 1'b1; pcnt <= 0; end
        else pcnt <= pcnt + 1;
      end else if (bus.o_ring_drive && !peer_tip) begin
        if (pcnt == 4) begin peer_tip <= 1'b1; pcnt <= 0; end
        else pcnt <= pcnt + 1;
      end else begin
        pcnt <= 0;
      end
      if (peer_ring && !bus.o_tip_drive)  peer_ring <= 1'b0;
      if (peer_tip  && !bus.o_ring_drive) peer_tip  <= 1'b0;
    end
  end

  // Log each bit as its drive rises; tally pulses and illegal double drives
  logic prev_tip = 1'b0, prev_ring = 1'b0;
  logic log_bits [0:63];
  int   log_n = 0, done_n = 0, err_n = 0, both_n = 0;
  always @(posedge clk) begin
    prev_tip  <= bus.o_tip_drive;
    prev_ring <= bus.o_ring_drive;
    if (bus.o_tip_drive && !prev_tip && log_n < 64) begin
      log_bits[log_n] <= 1'b0; log_n <= log_n + 1;
    end else if (bus.o_ring_drive && !prev_ring && log_n < 64) begin
      log_bits[log_n] <= 1'b1; log_n <= log_n + 1;
    end
    if (bus.o_done === 1'b1)  done_n <= done_n + 1;
    if (bus.o_error === 1'b1) err_n  <= err_n + 1;
    if (bus.o_tip_drive === 1'b1 && bus.o_ring_drive === 1'b1) both_n <= both_n + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (bus.o_done === 1'b1) begin seen = 1'b1; break; end
    end
  endtask

  function automatic logic [7:0] log_byte(input int start);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = log_bits[start + i];
    return v;
  endfunction

  initial begin
    bit seen;
    int start, d0, e0, hi, cyc, drove;

    bus.i_data   = 8'h00;
    bus.i_enable = 1'b1;

    // Reset held two cycles with enable high
    rst = 1'b1;
    tick(2);
    chk("rst_tip_drive",  32'(bus.o_tip_drive),  0);
    chk("rst_ring_drive", 32'(bus.o_ring_drive), 0);
    chk("rst_busy",       32'(bus.o_busy),       0);
    chk("rst_done",       32'(bus.o_done),       0);
    chk("rst_error",      32'(bus.o_error),      0);
    rst = 1'b0;
    bus.i_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("post_rst_drives", 32'({bus.o_tip_drive, bus.o_ring_drive, bus.o_busy}), 0);
    end

    // Byte 0xA5 with responsive peer; enable pulses during transfer are ignored
    peer_en = 1'b1;
    start = log_n; d0 = done_n; e0 = err_n;
    bus.i_data = 8'hA5; bus.i_enable = 1'b1;
    tick(1);
    bus.i_enable = 1'b0;
    chk("a5_busy_after_accept", 32'(bus.o_busy), 1);
    chk("a5_no_drive_waitidle", 32'({bus.o_tip_drive, bus.o_ring_drive}), 0);
    tick(1);
    chk("a5_first_drive_ring", 32'({bus.o_tip_drive, bus.o_ring_drive}), 32'b01);
    bus.i_data = 8'h3C; bus.i_enable = 1'b1;
    tick(20);
    bus.i_enable = 1'b0;
    wait_done(400, seen);
    chk("a5_done_seen",    32'(seen), 1);
    chk("a5_busy_at_done", 32'(bus.o_busy), 0);
    tick(1);
    chk("a5_done_one_cycle", 32'({bus.o_done, bus.o_busy}), 0);
    chk("a5_bit_count", 32'(log_n - start), 8);
    chk("a5_bits",      32'(log_byte(start)), 32'hA5);
    chk("a5_done_count", 32'(done_n - d0), 1);
    chk("a5_no_error",   32'(err_n - e0), 0);
    tick(4);

    // Silent peer: tip held in ASSERT until timeout
    peer_en = 1'b0;
    tick(2);
    bus.i_data = 8'h00; bus.i_enable = 1'b1;
    tick(1);
    bus.i_enable = 1'b0;
    tick(1);
    chk("tmo_tip_drive", 32'({bus.o_tip_drive, bus.o_ring_drive}), 32'b10);
    hi = 1; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (bus.o_error === 1'b1) begin seen = 1'b1; break; end
      if (bus.o_tip_drive === 1'b1) hi++;
    end
    chk("tmo_error_seen", 32'(seen), 1);
    chk("tmo_assert_cycles_16_17", 32'(hi >= 16 && hi <= 17), 1);
    chk("tmo_err_cycle_outputs", 32'({bus.o_tip_drive, bus.o_ring_drive, bus.o_busy}), 0);
    tick(1);
    chk("tmo_after_error", 32'({bus.o_error, bus.o_tip_drive, bus.o_ring_drive}), 0);

    // Ring held low before start: never drives, times out in WAITIDLE
    ring_hold = 1'b1;
    tick(3);
    bus.i_data = 8'h5A; bus.i_enable = 1'b1;
    tick(1);
    bus.i_enable = 1'b0;
    cyc = 0; drove = 0; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1); cyc++;
      if (bus.o_tip_drive === 1'b1 || bus.o_ring_drive === 1'b1) drove++;
      if (bus.o_error === 1'b1) begin seen = 1'b1; break; end
    end
    chk("hold_error_seen", 32'(seen), 1);
    chk("hold_never_drove", 32'(drove), 0);
    chk("hold_wait_cycles_16_18", 32'(cyc >= 16 && cyc <= 18), 1);
    ring_hold = 1'b0;
    tick(4);

    // Reset during the 4th bit's ASSERT of 0xFF
    peer_en = 1'b1;
    start = log_n; d0 = done_n;
    bus.i_data = 8'hFF; bus.i_enable = 1'b1;
    tick(1);
    bus.i_enable = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (log_n - start >= 4) break;
      tick(1);
    end
    chk("rstmid_reached_bit4", 32'(log_n - start), 4);
    chk("rstmid_ring_driving", 32'(bus.o_ring_drive), 1);
    rst = 1'b1;
    tick(1);
    chk("rstmid_outputs", 32'({bus.o_ring_drive, bus.o_tip_drive, bus.o_busy, bus.o_done}), 0);
    rst = 1'b0;
    tick(20);
    chk("rstmid_stays_idle", 32'({bus.o_ring_drive, bus.o_tip_drive, bus.o_busy}), 0);
    chk("rstmid_no_done", 32'(done_n - d0), 0);

    // Back-to-back 0x00 then 0xFF, second enable on the cycle after done
    start = log_n; d0 = done_n; e0 = err_n;
    bus.i_data = 8'h00; bus.i_enable = 1'b1;
    tick(1);
    bus.i_enable = 1'b0;
    wait_done(400, seen);
    chk("b2b_first_done", 32'(seen), 1);
    tick(1);
    bus.i_data = 8'hFF; bus.i_enable = 1'b1;
    tick(1);
    bus.i_enable = 1'b0;
    chk("b2b_second_accept", 32'(bus.o_busy), 1);
    wait_done(400, seen);
    chk("b2b_second_done", 32'(seen), 1);
    tick(2);
    chk("b2b_bit_count",  32'(log_n - start), 16);
    chk("b2b_byte0_bits", 32'(log_byte(start)), 32'h00);
    chk("b2b_byte1_bits", 32'(log_byte(start + 8)), 32'hFF);
    chk("b2b_done_count", 32'(done_n - d0), 2);
    chk("b2b_no_error",   32'(err_n - e0), 0);
    chk("never_both_drives", 32'(both_n), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
